// File: rtl/uc_pkg.sv
// Shared opcode constants, ALU codes, FSM state encoding and control-word
// layout for the processor control unit.
package uc_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALU_W    = 3;

    typedef enum logic [2:0] {
        ARRANQUE = 3'd0,
        EJECUTA  = 3'd1,
        LOAD_WB  = 3'd2,
        RET_WB   = 3'd3,
        PARADO   = 3'd4
    } estado_t;

    // Instruction classes that decide the next FSM state from EJECUTA.
    typedef enum logic [2:0] {
        CLS_SIMPLE    = 3'd0,
        CLS_LOAD      = 3'd1,
        CLS_RET       = 3'd2,
        CLS_HALT      = 3'd3,
        CLS_RESERVADO = 3'd4
    } clase_t;

    // Prefix patterns for opcode families; compared against the top bits only.
    localparam logic       OP_ALU_PFX   = 1'b1;
    localparam logic [3:0] OP_LI_PFX    = 4'b0000;
    localparam logic [4:0] OP_LOAD_PFX  = 5'b00101;
    localparam logic [3:0] OP_STORE_PFX = 4'b0011;

    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_JNZ  = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_JR   = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_CALL = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_RET  = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'b010001;

    localparam logic [ALU_W-1:0] ALU_NINGUNA = 3'b000;

    typedef struct packed {
        logic             s_inc;
        logic             s_inm;
        logic             we3;
        logic             wez;
        logic             salto_r;
        logic             guardar_mem;
        logic             activar_mem;
        logic             sel_dir_mem;
        logic             activar_pila;
        logic             push_pila;
        logic             sel_pila;
        logic             pc_en;
        logic             s_mem;
        logic [ALU_W-1:0] op_alu;
    } ctrl_t;

    localparam ctrl_t CTRL_NULO = '0;

endpackage

// File: rtl/dec_instr.sv
// Combinational instruction decoder: control word and instruction class for
// the opcode currently presented in the EJECUTA state.
module dec_instr
    import uc_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output ctrl_t               ctrl_c,
    output clase_t              clase_c
);

    always_comb begin
        ctrl_c        = CTRL_NULO;
        ctrl_c.s_inc  = 1'b1;
        ctrl_c.pc_en  = 1'b1;
        ctrl_c.op_alu = ALU_NINGUNA;
        clase_c       = CLS_SIMPLE;

        if (opcode[5] == OP_ALU_PFX) begin
            ctrl_c.op_alu = opcode[4:2];
            ctrl_c.we3    = 1'b1;
            ctrl_c.wez    = 1'b1;
        end else if (opcode[5:2] == OP_LI_PFX) begin
            ctrl_c.we3   = 1'b1;
            ctrl_c.s_inm = 1'b1;
        end else if (opcode == OP_J) begin
            ctrl_c.s_inc = 1'b0;
        end else if (opcode == OP_JZ) begin
            ctrl_c.s_inc = ~z;
        end else if (opcode == OP_JNZ) begin
            ctrl_c.s_inc = z;
        end else if (opcode == OP_JR) begin
            ctrl_c.salto_r = 1'b1;
        end else if (opcode == OP_CALL) begin
            ctrl_c.s_inc        = 1'b0;
            ctrl_c.activar_pila = 1'b1;
            ctrl_c.push_pila    = 1'b1;
        end else if (opcode == OP_RET) begin
            // Pop now; the return address is loaded in RET_WB.
            ctrl_c.activar_pila = 1'b1;
            ctrl_c.pc_en        = 1'b0;
            clase_c             = CLS_RET;
        end else if (opcode[5:1] == OP_LOAD_PFX) begin
            ctrl_c.activar_mem = 1'b1;
            ctrl_c.sel_dir_mem = 1'b1;
            ctrl_c.pc_en       = 1'b0;
            clase_c            = CLS_LOAD;
        end else if (opcode[5:2] == OP_STORE_PFX) begin
            ctrl_c.activar_mem = 1'b1;
            ctrl_c.guardar_mem = 1'b1;
        end else if (opcode == OP_NOP) begin
            clase_c = CLS_SIMPLE;
        end else if (opcode == OP_HALT) begin
            ctrl_c.pc_en = 1'b0;
            clase_c      = CLS_HALT;
        end else begin
            // Reserved opcodes execute as NOP and are flagged by the FSM.
            clase_c = CLS_RESERVADO;
        end
    end

endmodule

// File: rtl/unidad_control.sv
// Processor control unit: start-up/execute/write-back/halt FSM around the
// instruction decoder, plus the sticky illegal-opcode flag.
module unidad_control
    import uc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic                selectorMuxSaltoR,
    output logic                guardarMemoriaDatos,
    output logic                activarMemoria,
    output logic                selectorMuxDireccionMemoriaDatos,
    output logic                activarPilaSubRutinas,
    output logic                pushPilaSubRutinas,
    output logic                selectorMuxPilaSubRutinas,
    output logic [ALU_W-1:0]    op_alu,
    output logic                pc_en,
    output logic                s_mem,
    output logic                ilegal
);

    estado_t estado_q, estado_d;
    logic    ilegal_q, ilegal_d;
    ctrl_t   dec_ctrl;
    clase_t  dec_clase;
    ctrl_t   ctrl;

    dec_instr u_dec_instr (
        .opcode  (opcode),
        .z       (z),
        .ctrl_c  (dec_ctrl),
        .clase_c (dec_clase)
    );

    // State and sticky flag, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q <= ARRANQUE;
            ilegal_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ilegal_q <= ilegal_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        ilegal_d = ilegal_q;
        ctrl     = CTRL_NULO;

        case (estado_q)
            ARRANQUE: begin
                // Program memory needs one cycle before the first instruction is valid.
                estado_d = EJECUTA;
            end
            EJECUTA: begin
                ctrl = dec_ctrl;
                case (dec_clase)
                    CLS_LOAD:      estado_d = LOAD_WB;
                    CLS_RET:       estado_d = RET_WB;
                    CLS_HALT:      estado_d = PARADO;
                    CLS_RESERVADO: ilegal_d = 1'b1;
                    default:       estado_d = EJECUTA;
                endcase
            end
            LOAD_WB: begin
                ctrl.we3   = 1'b1;
                ctrl.s_mem = 1'b1;
                ctrl.s_inc = 1'b1;
                ctrl.pc_en = 1'b1;
                estado_d   = EJECUTA;
            end
            RET_WB: begin
                ctrl.sel_pila = 1'b1;
                ctrl.s_inc    = 1'b1;
                ctrl.pc_en    = 1'b1;
                estado_d      = EJECUTA;
            end
            PARADO: begin
                estado_d = PARADO;
            end
            default: begin
                estado_d = ARRANQUE;
            end
        endcase
    end

    assign s_inc                            = ctrl.s_inc;
    assign s_inm                            = ctrl.s_inm;
    assign we3                              = ctrl.we3;
    assign wez                              = ctrl.wez;
    assign selectorMuxSaltoR                = ctrl.salto_r;
    assign guardarMemoriaDatos              = ctrl.guardar_mem;
    assign activarMemoria                   = ctrl.activar_mem;
    assign selectorMuxDireccionMemoriaDatos = ctrl.sel_dir_mem;
    assign activarPilaSubRutinas            = ctrl.activar_pila;
    assign pushPilaSubRutinas               = ctrl.push_pila;
    assign selectorMuxPilaSubRutinas        = ctrl.sel_pila;
    assign op_alu                           = ctrl.op_alu;
    assign pc_en                            = ctrl.pc_en;
    assign s_mem                            = ctrl.s_mem;
    assign ilegal                           = ilegal_q;

endmodule
